exec_stage: RTL
===============

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter DATA_W, default 24, operand/result width.
REQ-002 Parameter REG_AW, default 4, register-address width.
REQ-003 Parameter CNT_W, default 16, retire-counter width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 validD  in  1  decode stage holds a real instruction.
REQ-007 ctrlD  in  exec_ctrl_t  regWrite, memWrite, memToReg, pcSrc, flagUpdate, aluSrc, aluCtrl[1:0], cond[1:0].
REQ-008 rd1D, rd2D  in  DATA_W each  register-file read data.
REQ-009 ra1D, ra2D, wa3D  in  REG_AW each  source and destination addresses.
REQ-010 immD  in  DATA_W  sign-extended immediate.
REQ-011 stallE  in  1  hold E register and flag; flushE  in  1  load bubble into E.
REQ-012 regWriteM, wa3M, aluResM  in  1/REG_AW/DATA_W  memory-stage forwarding source.
REQ-013 regWriteW, wa3W, resultW  in  1/REG_AW/DATA_W  writeback forwarding source.
REQ-014 validE  out  1  E holds a real instruction.
REQ-015 aluResE, writeDataE  out  DATA_W each  ALU result; forwarded rd2 for stores.
REQ-016 wa3E  out  REG_AW  destination in E.
REQ-017 regWriteE, memWriteE, memToRegE, pcSrcE  out  1 each  condition-gated enables.
REQ-018 zeroFlag  out  1  architectural Z flag register.
REQ-019 stallD  out  1  load-use hazard request to fetch/decode.
REQ-020 retireCnt  out  CNT_W  instructions retired through E.

Function
REQ-021 E register (validE, ctrl, operands, addresses, imm) SHALL load D inputs on rising edge when stallE=0; hold when stallE=1.
REQ-022 Priority at edge: stallE (hold) > flushE (bubble) > stallD (bubble) > load; bubble = validE=0, all ctrl enables 0.
REQ-023 stallD SHALL be combinational: validD & validE & memToRegE-stored & regWrite-stored & (wa3E==ra1D | (wa3E==ra2D & !ctrlD.aluSrc)).
REQ-024 Forwarding per source operand: match on M (regWriteM & wa3M==raE) takes aluResM; else match on W takes resultW; else stored rd; no hardwired-zero register.
REQ-025 srcB = aluSrc ? immE : forwarded rd2; writeDataE = forwarded rd2 always.
REQ-026 aluCtrl: 00 add, 01 sub (A-B), 10 and, 11 or; result mod 2^DATA_W, no carry out.
REQ-027 cond: 00 always, 01 if zeroFlag=1, 10 if zeroFlag=0, 11 never; condPass evaluated against current zeroFlag.
REQ-028 regWriteE/memWriteE/pcSrcE/memToRegE = stored enable & validE & condPass, combinational.
REQ-029 zeroFlag SHALL update to (aluResE==0) at edge when validE & flagUpdate & condPass & !stallE; never updates on bubble or stall.
REQ-030 retireCnt SHALL increment at edge when validE & condPass & !stallE; wraps from 2^CNT_W-1 to 0.
REQ-031 stallE with flushE same cycle: hold wins, flush applies first unstalled edge only if still asserted.

Reset
REQ-032 rst SHALL immediately clear validE, all stored enables, zeroFlag, retireCnt, and E data/address fields to 0; all gated outputs read 0.
REQ-033 rst mid-stall or mid-hazard SHALL discard the held instruction; first post-reset edge loads D normally.

Structure
REQ-034 Package exec_pkg SHALL hold exec_ctrl_t, aluCtrl and cond enumerations, and default DATA_W/REG_AW/CNT_W.
REQ-035 Forwarding selection SHALL be one sub-module fwd_unit, instantiated once per source operand.

Verification
REQ-036 add r1=5 + r2=7, no hazards -> next cycle aluResE=12, regWriteE=1, retireCnt=1.
REQ-037 sub 3-3 with flagUpdate, then cond=01 instruction -> zeroFlag=1 after edge, second instruction regWriteE=1; with cond=10 regWriteE=0 and retireCnt unchanged.
REQ-038 M writes r4=0x00000A, W writes r4=0x000003, E reads r4 -> A operand 0x00000A (M priority).
REQ-039 Load to r5 in E, D reads r5 -> stallD=1 one cycle, next E is bubble (validE=0), then instruction executes with W-forwarded data.
REQ-040 0xFFFFFF + 1 -> aluResE=0, zeroFlag=1; retireCnt at 0xFFFF retires -> 0x0000.
REQ-041 rst asserted while stallE=1 with valid E -> outputs 0 without clock edge; zeroFlag=0.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and default widths for the execute stage.
package exec_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned REG_AW_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    COND_AL = 2'b00,
    COND_EQ = 2'b01,
    COND_NE = 2'b10,
    COND_NV = 2'b11
  } cond_e;

  typedef struct packed {
    logic      regWrite;
    logic      memWrite;
    logic      memToReg;
    logic      pcSrc;
    logic      flagUpdate;
    logic      aluSrc;
    alu_ctrl_e aluCtrl;
    cond_e     cond;
  } exec_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux: memory stage beats writeback beats register file.
module fwd_unit
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] wa3_m,
  input  logic [DATA_W-1:0] alu_res_m,
  input  logic              reg_write_w,
  input  logic [REG_AW-1:0] wa3_w,
  input  logic [DATA_W-1:0] result_w,
  output logic [DATA_W-1:0] src_c
);

  // Youngest producer wins; register 0 is an ordinary register here.
  always_comb begin
    src_c = rd;
    if (reg_write_w && (wa3_w == ra)) src_c = result_w;
    if (reg_write_m && (wa3_m == ra)) src_c = alu_res_m;
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: E pipeline register, forwarding, ALU, condition gating,
// Z flag, load-use hazard detection and retire counter.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validD,
  input  exec_ctrl_t        ctrlD,
  input  logic [DATA_W-1:0] rd1D,
  input  logic [DATA_W-1:0] rd2D,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  input  logic [REG_AW-1:0] wa3D,
  input  logic [DATA_W-1:0] immD,
  input  logic              stallE,
  input  logic              flushE,
  input  logic              regWriteM,
  input  logic [REG_AW-1:0] wa3M,
  input  logic [DATA_W-1:0] aluResM,
  input  logic              regWriteW,
  input  logic [REG_AW-1:0] wa3W,
  input  logic [DATA_W-1:0] resultW,
  output logic              validE,
  output logic [DATA_W-1:0] aluResE,
  output logic [DATA_W-1:0] writeDataE,
  output logic [REG_AW-1:0] wa3E,
  output logic              regWriteE,
  output logic              memWriteE,
  output logic              memToRegE,
  output logic              pcSrcE,
  output logic              zeroFlag,
  output logic              stallD,
  output logic [CNT_W-1:0]  retireCnt
);

  logic              valid_q, valid_d;
  exec_ctrl_t        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] ra1_q, ra1_d;
  logic [REG_AW-1:0] ra2_q, ra2_d;
  logic [REG_AW-1:0] wa3_q, wa3_d;
  logic              zero_q, zero_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] src_a_c, fwd_b_c, src_b_c, alu_res_c;
  logic              cond_pass_c, fire_c, hazard_c;

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .ra          (ra1_q),
    .rd          (rd1_q),
    .reg_write_m (regWriteM),
    .wa3_m       (wa3M),
    .alu_res_m   (aluResM),
    .reg_write_w (regWriteW),
    .wa3_w       (wa3W),
    .result_w    (resultW),
    .src_c       (src_a_c)
  );

  fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .ra          (ra2_q),
    .rd          (rd2_q),
    .reg_write_m (regWriteM),
    .wa3_m       (wa3M),
    .alu_res_m   (aluResM),
    .reg_write_w (regWriteW),
    .wa3_w       (wa3W),
    .result_w    (resultW),
    .src_c       (fwd_b_c)
  );

  // Load-use hazard: a load in E feeding a register the D instruction reads.
  always_comb begin
    hazard_c = 1'b0;
    if (validD && valid_q && ctrl_q.memToReg && ctrl_q.regWrite) begin
      hazard_c = (wa3_q == ra1D) || ((wa3_q == ra2D) && !ctrlD.aluSrc);
    end
  end

  // ALU with wrap-around arithmetic.
  always_comb begin
    src_b_c = ctrl_q.aluSrc ? imm_q : fwd_b_c;
    case (ctrl_q.aluCtrl)
      ALU_ADD: alu_res_c = src_a_c + src_b_c;
      ALU_SUB: alu_res_c = src_a_c - src_b_c;
      ALU_AND: alu_res_c = src_a_c & src_b_c;
      ALU_OR:  alu_res_c = src_a_c | src_b_c;
      default: alu_res_c = '0;
    endcase
  end

  // Condition check against the architectural flag as it stands now.
  always_comb begin
    case (ctrl_q.cond)
      COND_AL: cond_pass_c = 1'b1;
      COND_EQ: cond_pass_c = zero_q;
      COND_NE: cond_pass_c = !zero_q;
      default: cond_pass_c = 1'b0;
    endcase
    fire_c = valid_q && cond_pass_c;
  end

  // Next state: stall holds everything, otherwise retire, update flag and load/bubble.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    wa3_d   = wa3_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    if (!stallE) begin
      if (fire_c) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ctrl_q.flagUpdate) zero_d = (alu_res_c == '0);
      end
      rd1_d = rd1D;
      rd2_d = rd2D;
      imm_d = immD;
      ra1_d = ra1D;
      ra2_d = ra2D;
      wa3_d = wa3D;
      if (flushE || hazard_c) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else begin
        valid_d = validD;
        ctrl_d  = ctrlD;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wa3_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      wa3_q   <= wa3_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign validE     = valid_q;
  assign aluResE    = alu_res_c;
  assign writeDataE = fwd_b_c;
  assign wa3E       = wa3_q;
  assign regWriteE  = ctrl_q.regWrite & fire_c;
  assign memWriteE  = ctrl_q.memWrite & fire_c;
  assign memToRegE  = ctrl_q.memToReg & fire_c;
  assign pcSrcE     = ctrl_q.pcSrc & fire_c;
  assign zeroFlag   = zero_q;
  assign stallD     = hazard_c;
  assign retireCnt  = cnt_q;

endmodule
